// File: rtl/switch_debounce_pkg.sv
// Shared board-level constants for the switch input path and helpers that
// derive the debounce timing from them.
package switch_debounce_pkg;

  localparam int SWITCH_COUNT = 12;
  localparam int CLK_HZ       = 100_000_000;
  localparam int DEBOUNCE_MS  = 10;
  localparam int STATUS_W     = 32;

  function automatic int debounce_cycles(input int clk_hz, input int ms);
    return (clk_hz / 1000) * ms;
  endfunction

  // Counter must hold DEBOUNCE_CYCLES-1; never narrower than one bit.
  function automatic int cnt_width(input int cycles);
    int w;
    w = $clog2(cycles);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/switch_debounce_bit.sv
// One switch line: 2-FF synchroniser, stability counter, accepted level and
// registered rise/fall pulses. accept is exposed for the shared changed flag.
module switch_debounce_bit
  import switch_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = debounce_cycles(CLK_HZ, DEBOUNCE_MS),
  parameter int CNT_W           = cnt_width(DEBOUNCE_CYCLES)
) (
  input  logic clk,
  input  logic rstn,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall,
  output logic accept
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_p0;
  logic             sync_p1;
  logic [CNT_W-1:0] cnt;
  logic             mismatch;

  assign mismatch = sync_p1 ^ level;
  assign accept   = mismatch && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      cnt     <= '0;
      level   <= 1'b0;
      rise    <= 1'b0;
      fall    <= 1'b0;
    end else begin
      // synchroniser stage boundary
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
      // a bounce back to the stable level restarts timing from zero
      if (!mismatch || accept) cnt <= '0;
      else                     cnt <= cnt + CNT_W'(1);
      if (accept) level <= sync_p1;
      rise <= accept &  sync_p1;
      fall <= accept & ~sync_p1;
    end
  end

endmodule

// File: rtl/switch_debounce.sv
// Debounced board switch bank: per-line conditioning plus a sticky changed
// flag and a packed status word for the CPU read path.
module switch_debounce
  import switch_debounce_pkg::*;
#(
  parameter int WIDTH           = SWITCH_COUNT,
  parameter int DEBOUNCE_CYCLES = debounce_cycles(CLK_HZ, DEBOUNCE_MS),
  parameter int CNT_W           = cnt_width(DEBOUNCE_CYCLES)
) (
  input  logic                i_clk,
  input  logic                i_rstn,
  input  logic [WIDTH-1:0]    i_switch,
  input  logic                i_clear,
  output logic [WIDTH-1:0]    o_switch,
  output logic [WIDTH-1:0]    o_rise,
  output logic [WIDTH-1:0]    o_fall,
  output logic                o_changed,
  output logic [STATUS_W-1:0] o_status
);

  logic [WIDTH-1:0] accept;

  for (genvar b = 0; b < WIDTH; b++) begin : g_bit
    switch_debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_bit (
      .clk   (i_clk),
      .rstn  (i_rstn),
      .raw   (i_switch[b]),
      .level (o_switch[b]),
      .rise  (o_rise[b]),
      .fall  (o_fall[b]),
      .accept(accept[b])
    );
  end

  // Set has priority over clear so an event landing with a clear is never lost.
  always_ff @(posedge i_clk) begin
    if (!i_rstn)      o_changed <= 1'b0;
    else if (|accept) o_changed <= 1'b1;
    else if (i_clear) o_changed <= 1'b0;
  end

  assign o_status = {o_changed, {(STATUS_W - 1 - WIDTH){1'b0}}, o_switch};

endmodule

// File: tb/tb_switch_debounce.sv
// Scenario bench for switch_debounce with a short debounce window; expected
// output vectors are queued as stimulus is applied and compared after each edge.
module tb_switch_debounce;

  localparam int W  = 12;
  localparam int D  = 4;
  localparam int CW = 3;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         clear = 1'b0;
  logic [W-1:0] raw = '0;
  logic [W-1:0] level, rise, fall;
  logic         changed;
  logic [31:0]  status;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [W-1:0] lvl;
    logic [W-1:0] r;
    logic [W-1:0] f;
    logic         c;
    logic [31:0]  s;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  switch_debounce #(
    .WIDTH          (W),
    .DEBOUNCE_CYCLES(D),
    .CNT_W          (CW)
  ) dut (
    .i_clk    (clk),
    .i_rstn   (rstn),
    .i_switch (raw),
    .i_clear  (clear),
    .o_switch (level),
    .o_rise   (rise),
    .o_fall   (fall),
    .o_changed(changed),
    .o_status (status)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t mk(input logic [W-1:0] lvl, input logic [W-1:0] r,
                              input logic [W-1:0] f, input logic c);
    exp_t e;
    e.lvl = lvl;
    e.r   = r;
    e.f   = f;
    e.c   = c;
    e.s   = {c, 19'b0, lvl};
    return e;
  endfunction

  task automatic test_reset();
    exp_t e;
    for (int k = 1; k <= 22; k++) begin
      rstn = (k > 2);
      raw  = '0;
      q.push_back(mk('0, '0, '0, 1'b0));
      tick();
      e = q.pop_front();
      checks++;
      if ({level, rise, fall, changed, status} !== e) begin
        errors++;
        $display("FAIL reset step=%0d got sw=%h rise=%h fall=%h chg=%b st=%h want sw=%h rise=%h fall=%h chg=%b st=%h",
                 k, level, rise, fall, changed, status, e.lvl, e.r, e.f, e.c, e.s);
      end
    end
  endtask

  task automatic test_rise_latency();
    exp_t e;
    for (int k = 1; k <= 10; k++) begin
      raw[0] = 1'b1;
      q.push_back(mk((k >= 6) ? 12'h001 : 12'h000, (k == 6) ? 12'h001 : 12'h000, '0, k >= 6));
      tick();
      e = q.pop_front();
      checks++;
      if ({level, rise, fall, changed, status} !== e) begin
        errors++;
        $display("FAIL rise_latency step=%0d got sw=%h rise=%h fall=%h chg=%b st=%h want sw=%h rise=%h fall=%h chg=%b st=%h",
                 k, level, rise, fall, changed, status, e.lvl, e.r, e.f, e.c, e.s);
      end
    end
    checks++;
    if (status !== 32'h80000001) begin
      errors++;
      $display("FAIL rise_status got %h want %h", status, 32'h80000001);
    end
  endtask

  task automatic test_short_pulse();
    exp_t e;
    for (int k = 1; k <= 12; k++) begin
      raw[3] = (k <= 3);
      clear  = (k == 1);
      q.push_back(mk(12'h001, '0, '0, 1'b0));
      tick();
      e = q.pop_front();
      checks++;
      if ({level, rise, fall, changed, status} !== e) begin
        errors++;
        $display("FAIL short_pulse step=%0d got sw=%h rise=%h fall=%h chg=%b st=%h want sw=%h rise=%h fall=%h chg=%b st=%h",
                 k, level, rise, fall, changed, status, e.lvl, e.r, e.f, e.c, e.s);
      end
    end
    clear = 1'b0;
  endtask

  task automatic test_bounce();
    exp_t e;
    for (int k = 1; k <= 32; k++) begin
      raw[5] = (k <= 20) ? (((k - 1) / 2) % 2 == 0) : 1'b1;
      q.push_back(mk((k >= 26) ? 12'h021 : 12'h001, (k == 26) ? 12'h020 : 12'h000, '0, k >= 26));
      tick();
      e = q.pop_front();
      checks++;
      if ({level, rise, fall, changed, status} !== e) begin
        errors++;
        $display("FAIL bounce step=%0d got sw=%h rise=%h fall=%h chg=%b st=%h want sw=%h rise=%h fall=%h chg=%b st=%h",
                 k, level, rise, fall, changed, status, e.lvl, e.r, e.f, e.c, e.s);
      end
    end
  endtask

  task automatic test_clear_collision();
    exp_t e;
    for (int k = 1; k <= 9; k++) begin
      raw[0] = 1'b0;
      clear  = (k == 1) || (k == 6) || (k == 7);
      q.push_back(mk((k >= 6) ? 12'h020 : 12'h021, '0, (k == 6) ? 12'h001 : 12'h000, k == 6));
      tick();
      e = q.pop_front();
      checks++;
      if ({level, rise, fall, changed, status} !== e) begin
        errors++;
        $display("FAIL clear_collision step=%0d got sw=%h rise=%h fall=%h chg=%b st=%h want sw=%h rise=%h fall=%h chg=%b st=%h",
                 k, level, rise, fall, changed, status, e.lvl, e.r, e.f, e.c, e.s);
      end
    end
    clear = 1'b0;
  endtask

  task automatic test_reset_midcount();
    exp_t e;
    for (int k = 1; k <= 16; k++) begin
      rstn = !((k <= 2) || (k == 8));
      raw  = 12'hFFF;
      q.push_back(mk((k >= 14) ? 12'hFFF : 12'h000, (k == 14) ? 12'hFFF : 12'h000, '0, k >= 14));
      tick();
      e = q.pop_front();
      checks++;
      if ({level, rise, fall, changed, status} !== e) begin
        errors++;
        $display("FAIL reset_midcount step=%0d got sw=%h rise=%h fall=%h chg=%b st=%h want sw=%h rise=%h fall=%h chg=%b st=%h",
                 k, level, rise, fall, changed, status, e.lvl, e.r, e.f, e.c, e.s);
      end
    end
  endtask

  initial begin
    test_reset();
    test_rise_latency();
    test_short_pulse();
    test_bounce();
    test_clear_collision();
    test_reset_midcount();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
